// File: rtl/regs_wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: A/B writeback, issue, decode and write port.
// slave is the arbiter side; master is the pipeline / register-file side.
interface regs_wb_arbiter_if #(
  parameter int unsigned n = 8
);
  logic         a_valid;
  logic [3:0]   a_addr;
  logic [n-1:0] a_data;

  logic         b_valid;
  logic         b_ready;
  logic [3:0]   b_addr;
  logic [n-1:0] b_data;

  logic         issue_valid;
  logic [3:0]   issue_addr;

  logic [3:0]   rs1;
  logic [3:0]   rs2;
  logic [3:0]   rd;
  logic         stall;
  logic         bubble_req;

  logic         w;
  logic [3:0]   waddr;
  logic [n-1:0] wdata;
  logic         err;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  issue_valid, issue_addr,
    input  rs1, rs2, rd,
    output stall, bubble_req,
    output w, waddr, wdata, err
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output issue_valid, issue_addr,
    output rs1, rs2, rd,
    input  stall, bubble_req,
    input  w, waddr, wdata, err
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Shares the single register-file write port between pipeline writeback (A, priority) and a
// buffered multi-cycle writeback (B), and tracks busy destinations for decode-stage stalls.
module regs_wb_arbiter #(
  parameter int unsigned n     = 8,
  parameter int unsigned NREG  = 14,
  parameter int unsigned DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  regs_wb_arbiter_if.slave  bus
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [PW:0] CntFull = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [3:0]   addr;
    logic [n-1:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q;
  logic [NREG-1:0] busy_q, busy_d;
  logic            w_q, bubble_q, err_q, err_d;
  logic [3:0]      waddr_q;
  logic [n-1:0]    wdata_q;

  logic   full, push, pop;
  entry_t head;

  function automatic logic in_range(input logic [3:0] a);
    return {1'b0, a} < 5'(NREG);
  endfunction

  function automatic logic writable(input logic [3:0] a);
    return in_range(a) && (a != 4'd0);
  endfunction

  function automatic logic is_busy(input logic [NREG-1:0] b, input logic [3:0] a);
    return writable(a) && b[a];
  endfunction

  assign full = (cnt_q == CntFull);
  assign push = bus.b_valid & ~full;
  // B drains only in cycles where A leaves the port free.
  assign pop  = ~bus.a_valid & (cnt_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    busy_d = busy_q;
    if (pop && writable(head.addr)) begin
      busy_d[head.addr] = 1'b0;
    end
    // A fresh issue overrides a commit to the same register.
    if (bus.issue_valid && writable(bus.issue_addr)) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.a_valid && (!in_range(bus.a_addr) || is_busy(busy_q, bus.a_addr))) begin
      err_d = 1'b1;
    end
    if (pop && !in_range(head.addr)) begin
      err_d = 1'b1;
    end
    if (bus.issue_valid && is_busy(busy_q, bus.issue_addr)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: bus.b_addr, data: bus.b_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      w_q      <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (bus.a_valid) begin
        w_q     <= writable(bus.a_addr);
        waddr_q <= bus.a_addr;
        wdata_q <= bus.a_data;
      end else if (pop) begin
        w_q     <= writable(head.addr);
        waddr_q <= head.addr;
        wdata_q <= head.data;
      end else begin
        w_q <= 1'b0;
      end

      if (full && bus.a_valid) begin
        bubble_q <= 1'b1;
      end else if (!full) begin
        bubble_q <= 1'b0;
      end

      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign bus.b_ready    = ~full;
  assign bus.stall      = is_busy(busy_q, bus.rs1) | is_busy(busy_q, bus.rs2) |
                          is_busy(busy_q, bus.rd);
  assign bus.bubble_req = bubble_q;
  assign bus.w          = w_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.err        = err_q;

endmodule
